// File: rtl/wordle_pkg.sv
// wordle_pkg: shared constants for the Wordle scorer.
//   NUM_LETTERS / LW : default word length and bits per letter code
//   MAX_LETTER       : largest legal letter code (Z)
//   GRAY/YELLOW/GREEN: two-bit colour codes used in the result vector
//   ST_*             : FSM state encoding
package wordle_pkg;

  localparam int NUM_LETTERS = 5;
  localparam int LW          = 5;
  localparam int MAX_LETTER  = 25;

  localparam logic [1:0] GRAY   = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_GREEN  = 3'd2;
  localparam logic [2:0] ST_YELLOW = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/wordle_first_match.sv
// wordle_first_match: combinational search for the lowest-index answer letter
// that equals `letter` and has not yet been consumed.
//   letter : LW-bit letter code being looked up
//   answer : packed answer word, letter j at [LW*j +: LW]
//   used   : per-answer-letter consumed flags
//   hit    : a matching unused letter exists
//   sel    : one-hot select of that letter (all zero when hit=0)
module wordle_first_match #(
  parameter int NUM_LETTERS = 5,
  parameter int LW          = 5
) (
  input  logic [LW-1:0]             letter,
  input  logic [NUM_LETTERS*LW-1:0] answer,
  input  logic [NUM_LETTERS-1:0]    used,
  output logic                      hit,
  output logic [NUM_LETTERS-1:0]    sel
);

  // Ascending scan; once hit is set, later positions are ignored so only the
  // lowest matching index is selected.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int j = 0; j < NUM_LETTERS; j++) begin
      if (!hit && !used[j] && (answer[LW*j +: LW] == letter)) begin
        sel[j] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_scorer.sv
// wordle_scorer: scores one Wordle guess against a hidden answer, one letter
// per cycle (green pass, then yellow pass).
//   board_clk, reset : clock, asynchronous active-high reset
//   start            : begin scoring (only looked at in IDLE)
//   guess, answer    : packed words, letter i at [LW*i +: LW], i=0 leftmost
//   busy             : FSM is not in IDLE
//   done             : one-cycle pulse while in DONE
//   result           : colour of letter i at [2i+1:2i]
//   win, invalid     : all-green flag / illegal letter code flag
//   state_dbg        : current FSM state (ST_* encoding)
// Handshake: start is a level request; a run is accepted at the rising edge
// where state is IDLE and start=1. Results are valid from done and held until
// the next accepted start.
module wordle_scorer #(
  parameter int NUM_LETTERS = wordle_pkg::NUM_LETTERS,
  parameter int LW          = wordle_pkg::LW
) (
  input  logic                      board_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_LETTERS*LW-1:0] guess,
  input  logic [NUM_LETTERS*LW-1:0] answer,
  output logic                      busy,
  output logic                      done,
  output logic [2*NUM_LETTERS-1:0]  result,
  output logic                      win,
  output logic                      invalid,
  output logic [2:0]                state_dbg
);

  import wordle_pkg::GRAY;
  import wordle_pkg::YELLOW;
  import wordle_pkg::GREEN;
  import wordle_pkg::MAX_LETTER;
  import wordle_pkg::ST_IDLE;
  import wordle_pkg::ST_CHECK;
  import wordle_pkg::ST_GREEN;
  import wordle_pkg::ST_YELLOW;
  import wordle_pkg::ST_DONE;

  localparam int IW = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam int WW = NUM_LETTERS * LW;

  logic [2:0]               state_q,   state_d;
  logic [WW-1:0]            guess_q,   guess_d;
  logic [WW-1:0]            answer_q,  answer_d;
  logic [IW-1:0]            idx_q,     idx_d;
  logic [NUM_LETTERS-1:0]   used_q,    used_d;
  logic [2*NUM_LETTERS-1:0] result_q,  result_d;
  logic                     win_q,     win_d;
  logic                     invalid_q, invalid_d;

  // Letter/colour at the current index, and whole-word checks.
  logic [LW-1:0]          cur_g, cur_a;
  logic [1:0]             cur_res;
  logic                   bad_code;
  logic                   fm_hit;
  logic [NUM_LETTERS-1:0] fm_sel;

  always_comb begin
    cur_g    = '0;
    cur_a    = '0;
    cur_res  = GRAY;
    bad_code = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_g   = guess_q[LW*i +: LW];
        cur_a   = answer_q[LW*i +: LW];
        cur_res = result_q[2*i +: 2];
      end
      if ((guess_q[LW*i +: LW] > LW'(MAX_LETTER)) ||
          (answer_q[LW*i +: LW] > LW'(MAX_LETTER)))
        bad_code = 1'b1;
    end
  end

  wordle_first_match #(
    .NUM_LETTERS (NUM_LETTERS),
    .LW          (LW)
  ) u_first_match (
    .letter (cur_g),
    .answer (answer_q),
    .used   (used_q),
    .hit    (fm_hit),
    .sel    (fm_sel)
  );

  always_comb begin
    logic all_green;
    state_d   = state_q;
    guess_d   = guess_q;
    answer_d  = answer_q;
    idx_d     = idx_q;
    used_d    = used_q;
    result_d  = result_q;
    win_d     = win_q;
    invalid_d = invalid_q;
    all_green = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          guess_d   = guess;
          answer_d  = answer;
          result_d  = '0;
          win_d     = 1'b0;
          invalid_d = 1'b0;
          used_d    = '0;
          idx_d     = '0;
          state_d   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        idx_d = '0;
        if (bad_code) begin
          invalid_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_GREEN;
        end
      end

      ST_GREEN: begin
        if (cur_g == cur_a) begin
          for (int i = 0; i < NUM_LETTERS; i++) begin
            if (idx_q == IW'(i)) begin
              result_d[2*i +: 2] = GREEN;
              used_d[i]          = 1'b1;
            end
          end
        end
        if (idx_q == IW'(NUM_LETTERS - 1)) begin
          idx_d   = '0;
          state_d = ST_YELLOW;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_YELLOW: begin
        // Greens already own their answer letters via used_q, so only the
        // remaining letters are eligible for yellow credit.
        if ((cur_res != GREEN) && fm_hit) begin
          for (int i = 0; i < NUM_LETTERS; i++) begin
            if (idx_q == IW'(i)) result_d[2*i +: 2] = YELLOW;
          end
          used_d = used_q | fm_sel;
        end
        if (idx_q == IW'(NUM_LETTERS - 1)) begin
          idx_d     = '0;
          state_d   = ST_DONE;
          all_green = 1'b1;
          for (int i = 0; i < NUM_LETTERS; i++) begin
            if (result_d[2*i +: 2] != GREEN) all_green = 1'b0;
          end
          // Registered on entry so win is already valid while done is high.
          win_d = all_green;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      guess_q   <= '0;
      answer_q  <= '0;
      idx_q     <= '0;
      used_q    <= '0;
      result_q  <= '0;
      win_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      answer_q  <= answer_d;
      idx_q     <= idx_d;
      used_q    <= used_d;
      result_q  <= result_d;
      win_q     <= win_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign win       = win_q;
  assign invalid   = invalid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wordle_scorer.sv
// tb_wordle_scorer: randomized scoreboard bench for wordle_scorer.
module tb_wordle_scorer;

  localparam int NL = 5;
  localparam int LW = 5;
  localparam int WW = NL * LW;
  localparam int EW = 2 * NL + 2;   // {invalid, win, result}

  // ---------------- clock / reset ----------------
  logic board_clk = 1'b0;
  logic reset     = 1'b1;
  always #5 board_clk = ~board_clk;

  int cyc = 0;
  always @(posedge board_clk) cyc++;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [WW-1:0] guess = '0;
  logic [WW-1:0] answer = '0;
  logic          busy, done, win, invalid;
  logic [2*NL-1:0] result;
  logic [2:0]    state_dbg;

  wordle_scorer #(.NUM_LETTERS(NL), .LW(LW)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (start),
    .guess     (guess),
    .answer    (answer),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .win       (win),
    .invalid   (invalid),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WW-1:0] word(input string s);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) w[LW*i +: LW] = LW'(s[i] - 8'd65);
    return w;
  endfunction

  // Reference: greens first, then yellows from a per-letter count of the
  // answer letters not already matched green, handed out left to right.
  function automatic logic [EW-1:0] model(input logic [WW-1:0] g, input logic [WW-1:0] a);
    int cnt[32];
    logic [2*NL-1:0] r;
    bit bad;
    bit all_g;
    bad = 0;
    for (int i = 0; i < NL; i++)
      if (g[LW*i +: LW] > 25 || a[LW*i +: LW] > 25) bad = 1;
    if (bad) return {1'b1, 1'b0, {(2*NL){1'b0}}};
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      if (g[LW*i +: LW] == a[LW*i +: LW]) r[2*i +: 2] = 2'b10;
      else cnt[a[LW*i +: LW]]++;
    end
    for (int i = 0; i < NL; i++) begin
      if (r[2*i +: 2] != 2'b10 && cnt[g[LW*i +: LW]] > 0) begin
        r[2*i +: 2] = 2'b01;
        cnt[g[LW*i +: LW]]--;
      end
    end
    all_g = 1;
    for (int i = 0; i < NL; i++) if (r[2*i +: 2] != 2'b10) all_g = 0;
    return {1'b0, all_g, r};
  endfunction

  function automatic logic [WW-1:0] rand_word(input int bad_pct);
    logic [WW-1:0] w;
    for (int i = 0; i < NL; i++) begin
      if ($urandom_range(0, 99) < bad_pct) w[LW*i +: LW] = LW'($urandom_range(26, 31));
      else w[LW*i +: LW] = LW'($urandom_range(0, 5));
    end
    return w;
  endfunction

  // ---------------- monitor ----------------
  bit prev_done = 0;
  always @(negedge board_clk) begin
    logic [EW-1:0] e;
    int d;
    if (reset) begin
      prev_done = 0;
    end else begin
      if (prev_done) check("busy_after_done", {31'd0, busy}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("result",  {22'd0, result},  {22'd0, e[2*NL-1:0]});
          check("win",     {31'd0, win},     {31'd0, e[2*NL]});
          check("invalid", {31'd0, invalid}, {31'd0, e[2*NL+1]});
          check("latency", cyc, d);
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  // Waits for IDLE, raises start just after an edge (edge N = now); the DUT
  // samples it on the next edge. Expected done cycle is N+12 or N+2.
  task automatic issue(input logic [WW-1:0] g, input logic [WW-1:0] a, input bit hold);
    int t;
    logic [EW-1:0] e;
    @(posedge board_clk); #1;
    t = 0;
    while (busy && t < 100) begin
      @(posedge board_clk); #1;
      t++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    guess  = g;
    answer = a;
    start  = 1'b1;
    e = model(g, a);
    exp_q.push_back(e);
    due_q.push_back(cyc + (e[2*NL+1] ? 2 : 2 + 2 * NL));
    if (hold) begin
      // Start stays high: the run restarts once, 2*NL+3 edges later.
      exp_q.push_back(e);
      due_q.push_back(cyc + (e[2*NL+1] ? 2 : 2 + 2 * NL) + (e[2*NL+1] ? 3 : 2 * NL + 3));
      repeat (e[2*NL+1] ? 4 : 2 * NL + 4) @(posedge board_clk);
      #1 start = 1'b0;
    end else begin
      @(posedge board_clk); #1;
      start  = 1'b0;
      guess  = rand_word(0);   // must not affect the latched run
      answer = rand_word(0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge board_clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(posedge board_clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge board_clk);
    #1;
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_result",  {22'd0, result},  32'd0);
    check("rst_win",     {31'd0, win},     32'd0);
    check("rst_invalid", {31'd0, invalid}, 32'd0);
    reset = 1'b0;

    // Directed cases.
    issue(word("CRANE"), word("CRANE"), 0);
    issue(word("SPEED"), word("ABIDE"), 0);
    issue(word("LLAMA"), word("HELLO"), 0);
    begin
      logic [WW-1:0] g;
      g = word("CRANE");
      g[LW*2 +: LW] = 5'd27;
      issue(g, word("CRANE"), 0);
    end
    issue(word("EERIE"), word("THEME"), 0);
    drain();

    // Second start during YELLOW must be ignored.
    issue(word("SPEED"), word("ABIDE"), 0);
    repeat (7) @(posedge board_clk);
    check("in_yellow", {29'd0, state_dbg}, 32'd3);
    #1 guess = word("ZZZZZ");
    start = 1'b1;
    @(posedge board_clk); #1 start = 1'b0;
    drain();

    // Held results after done.
    check("hold_result", {22'd0, result}, {22'd0, model(word("SPEED"), word("ABIDE"))[2*NL-1:0]});

    // Start held high: two back-to-back runs.
    issue(word("LLAMA"), word("HELLO"), 1);
    drain();

    // Reset during GREEN.
    issue(word("CRANE"), word("CRANE"), 0);
    repeat (2) @(posedge board_clk);
    check("in_green", {29'd0, state_dbg}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy",    {31'd0, busy},    32'd0);
    check("mid_rst_done",    {31'd0, done},    32'd0);
    check("mid_rst_result",  {22'd0, result},  32'd0);
    check("mid_rst_win",     {31'd0, win},     32'd0);
    check("mid_rst_invalid", {31'd0, invalid}, 32'd0);
    exp_q.delete();
    due_q.delete();
    @(posedge board_clk); #1 reset = 1'b0;
    issue(word("CRANE"), word("CRANE"), 0);
    drain();

    // Randomized runs.
    for (int n = 0; n < 40; n++) begin
      logic [WW-1:0] g, a;
      g = rand_word(4);
      a = ($urandom_range(0, 9) == 0) ? g : rand_word(4);
      issue(g, a, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
